ssd_scan_encoder: RTL and testbench

Time-multiplexed seven-segment display controller, the parametrised successor to the static four-display output encoder. Sits between the roller/calculator datapath and the board's shared-segment display. Drives one digit at a time through a common segment bus with one-hot anode enables, and shows either the N roller values or the signed calculator result (magnitude plus minus sign). It adds tear-free frame latching and a sticky, blinking overflow indicator.

---
 rtl/ssd_scan_encoder_pkg.sv | 10 +
 rtl/ssd_driver.sv | 26 ++
 rtl/ssd_scan_encoder.sv | 119 +++++++++++
 tb/tb_ssd_scan_encoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ssd_scan_encoder_pkg.sv
// Shared glyph constants and sizing helpers for the scanned seven-segment encoder.
// Segment order everywhere is {g,f,e,d,c,b,a}, active low.
package ssd_scan_encoder_pkg;
  localparam logic [6:0] SSD_BLANK = 7'b1111111;
  localparam logic [6:0] SSD_MINUS = 7'b0111111;

  function automatic int ceil_div4(input int w);
    return (w + 3) / 4;
  endfunction
endpackage

// File: rtl/ssd_driver.sv
// Combinational hex-to-glyph decoder, active-low {g,f,e,d,c,b,a}.
module ssd_driver (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/ssd_scan_encoder.sv
// Time-multiplexed seven-segment controller: roller nibbles or signed result,
// frame-latched for tear-free scanning, plus a sticky blinking overflow LED.
module ssd_scan_encoder
  import ssd_scan_encoder_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SUM_W       = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] rollers,
  input  logic [SUM_W-1:0]      sum,
  input  logic                  overflow,
  input  logic                  M,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  overflow_led
);
  localparam int D     = ceil_div4(SUM_W);
  localparam int MAG_W = 4 * D;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int BC_W  = $clog2(BLINK_DIV);

  logic [RC_W-1:0]       ref_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  first_q;
  logic [4*N_DIGITS-1:0] sh_rollers;
  logic [SUM_W-1:0]      sh_sum;
  logic                  sh_m;
  logic                  ovf_q, phase;
  logic [BC_W-1:0]       blink_cnt;

  logic tick, last, latch;
  assign tick  = (ref_cnt == RC_W'(REFRESH_DIV - 1));
  assign last  = (idx == IDX_W'(N_DIGITS - 1));
  assign latch = tick & (last | first_q);

  // The first slot after reset latches and displays in the same edge, so it
  // reads the live inputs; every later slot reads the shadow frame.
  logic [N_DIGITS-1:0][3:0] src_r;
  logic [SUM_W-1:0]         src_sum, mag;
  logic                     src_m, neg;
  logic [D-1:0][3:0]        mag_v;
  logic [3:0]               roll_nib, mag_nib, nib;
  logic [6:0]               drv_seg, glyph;

  always_comb begin
    src_r    = first_q ? rollers : sh_rollers;
    src_sum  = first_q ? sum : sh_sum;
    src_m    = first_q ? M : sh_m;
    neg      = src_sum[SUM_W-1];
    mag      = neg ? (~src_sum + SUM_W'(1)) : src_sum;
    mag_v    = MAG_W'(mag);
    roll_nib = '0;
    mag_nib  = '0;
    for (int k = 0; k < N_DIGITS; k++)
      if (idx == IDX_W'(k)) roll_nib = src_r[k];
    for (int k = 0; k < D; k++)
      if (idx == IDX_W'(k)) mag_nib = mag_v[k];
    nib = src_m ? mag_nib : roll_nib;
  end

  ssd_driver u_drv (.hex(nib), .seg(drv_seg));

  always_comb begin
    glyph = SSD_BLANK;
    if (!src_m || idx < IDX_W'(D)) glyph = drv_seg;
    else if (idx == IDX_W'(D))     glyph = neg ? SSD_MINUS : SSD_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt    <= '0;
      idx        <= '0;
      first_q    <= 1'b1;
      sh_rollers <= '0;
      sh_sum     <= '0;
      sh_m       <= 1'b0;
      seg        <= SSD_BLANK;
      an         <= '1;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + RC_W'(1);
      if (tick) begin
        idx     <= last ? '0 : idx + IDX_W'(1);
        first_q <= 1'b0;
        seg     <= glyph;
        an      <= ~(N_DIGITS'(1) << idx);
      end
      if (latch) begin
        sh_rollers <= rollers;
        sh_sum     <= sum;
        sh_m       <= M;
      end
    end
  end

  // Overflow tracks live mode, not the frame: leaving mode 1 clears at once.
  always_ff @(posedge clk) begin
    if (reset || !M)   ovf_q <= 1'b0;
    else if (overflow) ovf_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !ovf_q) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BC_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BC_W'(1);
    end
  end

  assign overflow_led = ovf_q & ~phase;
endmodule

// File: tb/tb_ssd_scan_encoder.sv
// Directed bench for ssd_scan_encoder at REFRESH_DIV=4, BLINK_DIV=3.
module tb_ssd_scan_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rollers;
  logic [3:0]  sum;
  logic        overflow, M;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        overflow_led;
  int          errors = 0;
  int          checks = 0;

  ssd_scan_encoder #(
    .N_DIGITS(4), .SUM_W(4), .REFRESH_DIV(4), .BLINK_DIV(3)
  ) dut (
    .clk(clk), .reset(reset), .rollers(rollers), .sum(sum),
    .overflow(overflow), .M(M), .seg(seg), .an(an), .overflow_led(overflow_led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One slot later: digit enable and glyph both as given.
  task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es);
    step(4);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  logic [12:0] blink_pat;

  initial begin
    reset = 1'b1; M = 1'b0; rollers = 16'h4321; sum = 4'h0; overflow = 1'b0;
    step(3);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_led", 32'(overflow_led), 32'h0);
    reset = 1'b0;
    step(3);
    chk("slot0_still_blank", 32'(an), 32'hF);
    step(1);
    chk("d0_an", 32'(an), 32'hE);
    chk("d0_seg", 32'(seg), 32'h79);
    step(3);
    chk("d0_hold", 32'(an), 32'hE);
    step(1);
    chk("d1_an", 32'(an), 32'hD);
    chk("d1_seg", 32'(seg), 32'h24);
    slot("r_d2", 4'hB, 7'h30);
    slot("r_d3", 4'h7, 7'h19);

    // Mode change mid-frame waits a full frame.
    M = 1'b1; sum = 4'b1101;
    slot("mwait_d0", 4'hE, 7'h79);
    slot("mwait_d1", 4'hD, 7'h24);
    slot("mwait_d2", 4'hB, 7'h30);
    slot("mwait_d3", 4'h7, 7'h19);
    sum = 4'b1000;
    slot("m3_d0", 4'hE, 7'h30);
    slot("m3_d1", 4'hD, 7'h3F);
    slot("m3_d2", 4'hB, 7'h7F);
    slot("m3_d3", 4'h7, 7'h7F);
    sum = 4'b0111;
    slot("m8_d0", 4'hE, 7'h00);
    slot("m8_d1", 4'hD, 7'h3F);
    slot("m8_d2", 4'hB, 7'h7F);
    slot("m8_d3", 4'h7, 7'h7F);
    M = 1'b0; rollers = 16'h4321;
    slot("p7_d0", 4'hE, 7'h78);
    slot("p7_d1", 4'hD, 7'h7F);
    slot("p7_d2", 4'hB, 7'h7F);
    slot("p7_d3", 4'h7, 7'h7F);

    // Roller change with index at 2: rest of frame keeps old values.
    slot("old_d0", 4'hE, 7'h79);
    slot("old_d1", 4'hD, 7'h24);
    rollers = 16'h8765;
    slot("old_d2", 4'hB, 7'h30);
    slot("old_d3", 4'h7, 7'h19);
    slot("new_d0", 4'hE, 7'h12);
    slot("new_d1", 4'hD, 7'h02);
    slot("new_d2", 4'hB, 7'h78);
    slot("new_d3", 4'h7, 7'h00);

    // One-cycle overflow pulse in mode 1, then blink 1,1,1,0,0,0,...
    M = 1'b1; overflow = 1'b1;
    step(1);
    overflow = 1'b0;
    blink_pat = 13'b1_000_111_000_111;
    chk("led_on", 32'(overflow_led), 32'(blink_pat[0]));
    for (int p = 1; p <= 12; p++) begin
      step(1);
      chk($sformatf("blink_%0d", p), 32'(overflow_led), 32'(blink_pat[p]));
    end
    chk("blink_scan_an", 32'(an), 32'hB);
    chk("blink_scan_seg", 32'(seg), 32'h78);

    // One-cycle reset at index 3.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_led", 32'(overflow_led), 32'h0);
    step(3);
    chk("resume_blank", 32'(an), 32'hF);
    step(1);
    chk("resume_d0_an", 32'(an), 32'hE);
    chk("resume_d0_seg", 32'(seg), 32'h78);
    slot("resume_d1", 4'hD, 7'h7F);

    // Sticky set, mode-0 clear, mode-0 blocks set, reset beats set.
    overflow = 1'b1;
    step(1);
    overflow = 1'b0;
    chk("resticky_on", 32'(overflow_led), 32'h1);
    M = 1'b0;
    step(1);
    chk("m0_clear", 32'(overflow_led), 32'h0);
    overflow = 1'b1;
    step(2);
    chk("m0_blocks", 32'(overflow_led), 32'h0);
    M = 1'b1; reset = 1'b1;
    step(1);
    chk("rst_wins", 32'(overflow_led), 32'h0);
    reset = 1'b0;
    step(1);
    chk("set_after_rst", 32'(overflow_led), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
